// File: rtl/shift_calc_pkg.sv
// Shared types and helpers for the shift_calc half-period measurement block.
// SHIFT_AVG_EN selects the 4-deep averaging of accepted half-periods.
package shift_calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKED
    } state_t;

    localparam int AVG_DEPTH = 4;

    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing async levels into the clk domain.
// Flops clear to zero on the asynchronous active-high reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // metastability stage followed by the stable output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/shift_calc.sv
// Measures the sgn half-period and derives shift = half - lead (min 1).
// Define SHIFT_AVG_EN to average the last 4 accepted half-periods.
module shift_calc
    import shift_calc_pkg::*;
#(
    parameter int  CNT_MAX   = 255,
    parameter int  MIN_HALF  = 8,
    parameter int  SHIFT_DEF = 100,
    localparam int CNT_W     = cnt_w(CNT_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sgn,
    input  logic [CNT_W-1:0] lead,
    output logic [CNT_W-1:0] shift,
    output logic             shift_vld,
    output logic             no_sig
);

    localparam int HW = CNT_W + 1;
    localparam int SW = CNT_W + 2;

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] SH_DEF  = CNT_W'(SHIFT_DEF);
    localparam logic [HW-1:0]    MIN_H   = HW'(MIN_HALF);

    logic             sgn_s;
    logic             sgn_d_q;
    logic             sgn_edge;
    logic             sat;
    logic             accept;
    logic             full;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] shift_q, shift_d;
    logic             vld_q, vld_d;
    logic             nosig_q, nosig_d;
    logic [HW-1:0]    half;
    logic [HW-1:0]    eff;
    logic [HW-1:0]    lead_x;
    logic [CNT_W-1:0] shift_new;

    sync_2ff #(
        .WIDTH(1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(sgn),
        .q_o(sgn_s)
    );

    assign sgn_edge = sgn_s ^ sgn_d_q;
    assign sat      = (cnt_q == CNT_SAT);
    assign half     = HW'(cnt_q) + HW'(1);
    assign accept   = sgn_edge && !sat
                   && (state_q != IDLE)
                   && (half >= MIN_H);

`ifdef SHIFT_AVG_EN
    localparam int HN = AVG_DEPTH - 1;
    localparam int AW = $clog2(AVG_DEPTH);

    logic [CNT_W-1:0] hist_q [HN];
    logic [AW-1:0]    hcnt_q;
    logic [SW-1:0]    sum;

    // window sum of the current half and the previous accepted ones
    always_comb begin
        sum = SW'(half);
        for (int i = 0; i < HN; i++) begin
            sum = sum + SW'(hist_q[i]);
        end
    end

    assign full = (hcnt_q == AW'(HN));
    assign eff  = HW'(sum >> AW);

    // history shifts on acceptance; a timeout wipes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HN; i++) begin
                hist_q[i] <= '0;
            end
            hcnt_q <= '0;
        end else if (sat) begin
            for (int i = 0; i < HN; i++) begin
                hist_q[i] <= '0;
            end
            hcnt_q <= '0;
        end else if (accept) begin
            hist_q[0] <= half[CNT_W-1:0];
            for (int i = 1; i < HN; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
            if (!full) begin
                hcnt_q <= hcnt_q + AW'(1);
            end
        end
    end
`else
    assign full = 1'b1;
    assign eff  = half;
`endif

    assign lead_x    = HW'(lead);
    assign shift_new = (eff > lead_x)
                     ? CNT_W'(eff - lead_x)
                     : CNT_W'(1);

    // edge-relative cycle counter, saturating at CNT_MAX
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sgn_edge) begin
            cnt_d = '0;
        end else if (sat) begin
            cnt_d = cnt_q;
        end
    end

    // lock FSM and next output values; timeout beats a same-cycle edge
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        nosig_d = nosig_q;
        if (sat) begin
            state_d = sgn_edge ? ARMED : IDLE;
            shift_d = SH_DEF;
            nosig_d = 1'b1;
            vld_d   = (shift_q != SH_DEF);
        end else if (sgn_edge) begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED, LOCKED: begin
                    if (accept && full) begin
                        state_d = LOCKED;
                        shift_d = shift_new;
                        nosig_d = 1'b0;
                        vld_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // state, counter, delayed sgn and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sgn_d_q <= 1'b0;
            shift_q <= SH_DEF;
            vld_q   <= 1'b0;
            nosig_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_d_q <= sgn_s;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            nosig_q <= nosig_d;
        end
    end

    assign shift     = shift_q;
    assign shift_vld = vld_q;
    assign no_sig    = nosig_q;

endmodule

// File: tb/tb_shift_calc.sv
// Bench for shift_calc: directed cases plus random sgn segment trains,
// checked against an event-level model of the half-period rules.
module tb_shift_calc;

    localparam int CNT_MAX   = 255;
    localparam int MIN_HALF  = 8;
    localparam int SHIFT_DEF = 100;
    localparam int W         = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         sgn;
    logic [W-1:0] lead;
    logic [W-1:0] shift;
    logic         shift_vld;
    logic         no_sig;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int t;
        int sh;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];

    int m_st;
    int m_last;
    int m_shift;
    int m_nosig;
    int m_hist[$];
    int prev_sh = SHIFT_DEF;

    shift_calc #(
        .CNT_MAX(CNT_MAX),
        .MIN_HALF(MIN_HALF),
        .SHIFT_DEF(SHIFT_DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sgn(sgn),
        .lead(lead),
        .shift(shift),
        .shift_vld(shift_vld),
        .no_sig(no_sig)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got,
                            input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // collect pulses; a shift change must always come with a pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (shift_vld) got_q.push_back(ev_t'{cyc, int'(shift)});
            if (int'(shift) != prev_sh)
                check_eq("vld_on_change", int'(shift_vld), 1);
        end
        prev_sh <= int'(shift);
    end

    // ---- reference model: one call per sgn toggle ----
    function automatic void m_reset();
        m_st    = 0;
        m_last  = cyc;
        m_shift = SHIFT_DEF;
        m_nosig = 1;
        m_hist.delete();
    endfunction

    function automatic void m_timeout();
        if (m_shift != SHIFT_DEF)
            exp_q.push_back(ev_t'{m_last + CNT_MAX + 3, SHIFT_DEF});
        m_st    = 0;
        m_shift = SHIFT_DEF;
        m_nosig = 1;
        m_hist.delete();
    endfunction

    function automatic void m_flush();
        if (cyc >= m_last + CNT_MAX + 3) m_timeout();
    endfunction

    function automatic void m_edge(input int t, input int ld);
        int half = t - m_last;
        int h;
        int sum;
        if (half > CNT_MAX) m_timeout();
        m_last = t;
        if (m_st == 0) begin
            m_st = 1;
            return;
        end
        if (half < MIN_HALF) return;
`ifdef SHIFT_AVG_EN
        m_hist.push_back(half);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        if (m_hist.size() < 4) return;
        sum = 0;
        foreach (m_hist[i]) sum += m_hist[i];
        h = sum / 4;
`else
        sum = 0;
        h = half + sum;
`endif
        m_st    = 2;
        m_nosig = 0;
        m_shift = (h > ld) ? h - ld : 1;
        exp_q.push_back(ev_t'{t + 2, m_shift});
    endfunction

    // toggle sgn, hold for len cycles; lead may move mid-segment
    task automatic seg(input int len, input int ld);
        @(negedge clk);
        sgn = ~sgn;
        m_edge(cyc + 1, int'(lead));
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            if (i == 3) lead = W'(ld);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic scoreboard(input string tag);
        int n;
        m_flush();
        check_eq({tag, "_nvld"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size()
                                           : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_vld_t"}, got_q[i].t, exp_q[i].t);
            check_eq({tag, "_vld_sh"}, got_q[i].sh, exp_q[i].sh);
        end
        check_eq({tag, "_shift"}, int'(shift), m_shift);
        check_eq({tag, "_nosig"}, int'(no_sig), m_nosig);
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic int rand_len();
        int r = $urandom_range(0, 9);
        if (r < 2) return $urandom_range(2, 7);
        if (r == 9) return $urandom_range(250, 262);
        return $urandom_range(8, 120);
    endfunction

    initial begin
        rst  = 1'b1;
        sgn  = 1'b0;
        lead = W'(10);
        m_reset();

        // reset held while sgn toggles
        repeat (6) begin
            @(negedge clk);
            sgn = ~sgn;
        end
        #1;
        check_eq("rst_shift", int'(shift), SHIFT_DEF);
        check_eq("rst_vld", int'(shift_vld), 0);
        check_eq("rst_nosig", int'(no_sig), 1);
        @(negedge clk);
        sgn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        settle(5);

        // square wave, half = 50
        seg(50, 10);
        check_eq("sq_first_silent", got_q.size(), 0);
        repeat (5) seg(50, 10);
        settle(3);
        check_eq("sq_shift40", int'(shift), 40);
        check_eq("sq_nosig", int'(no_sig), 0);
        scoreboard("sq");

        // lead clamp
        seg(50, 60);
        seg(50, 60);
        check_eq("lead60", int'(shift), 1);
        seg(50, 49);
        seg(50, 49);
        check_eq("lead49", int'(shift), 1);
        seg(50, 48);
        seg(50, 48);
        check_eq("lead48", int'(shift), 2);
        seg(50, 10);
        seg(50, 10);
        check_eq("lead10", int'(shift), 40);
        #1;
        scoreboard("lead");

        // 3-clk glitch shortly after a real edge
        seg(5, 10);
        #1;
        scoreboard("pre_gl");
        seg(3, 10);
        seg(42, 10);
        check_eq("gl_vld", got_q.size(), 0);
        check_eq("gl_shift", int'(shift), 40);
        check_eq("gl_nosig", int'(no_sig), 0);
        seg(50, 10);
        seg(50, 10);
        #1;
        scoreboard("gl");

        // loss of signal, then resume at half = 30
        seg(300, 10);
        check_eq("los_pulses", got_q.size(), 2);
        check_eq("los_shift", int'(shift), SHIFT_DEF);
        check_eq("los_nosig", int'(no_sig), 1);
        seg(30, 10);
        check_eq("res_silent_sh", int'(shift), SHIFT_DEF);
        check_eq("res_silent_ns", int'(no_sig), 1);
        seg(30, 10);
`ifndef SHIFT_AVG_EN
        check_eq("res_shift20", int'(shift), 20);
`endif
        settle(300);
        scoreboard("los");

        // ramp of halves 40,44,48,52,56
        seg(40, 10);
        seg(44, 10);
        seg(48, 10);
        seg(52, 10);
        seg(56, 10);
`ifdef SHIFT_AVG_EN
        check_eq("avg_npulse", got_q.size(), 1);
        check_eq("avg_shift36", int'(shift), 36);
`else
        check_eq("ramp_npulse", got_q.size(), 4);
        check_eq("ramp_shift42", int'(shift), 42);
`endif
        seg(20, 10);
`ifdef SHIFT_AVG_EN
        check_eq("avg_shift40", int'(shift), 40);
`else
        check_eq("ramp_shift46", int'(shift), 46);
`endif
        settle(300);
        scoreboard("ramp");

        // random segment trains
        for (int s = 0; s < 8; s++) begin
            lead = W'($urandom_range(0, 80));
            repeat ($urandom_range(8, 24))
                seg(rand_len(), $urandom_range(0, 80));
            settle(($urandom_range(0, 1) != 0) ? 300 : 10);
            scoreboard("rnd");
        end

        // async reset while locked
        lead = W'(10);
        repeat (4) seg(50, 10);
        #1;
        scoreboard("pre_rst");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_shift", int'(shift), SHIFT_DEF);
        check_eq("arst_vld", int'(shift_vld), 0);
        check_eq("arst_nosig", int'(no_sig), 1);
        sgn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
        got_q.delete();
        exp_q.delete();
        seg(50, 10);
        seg(50, 10);
        settle(5);
        scoreboard("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
